seg7_scan_decoder: RTL and testbench

//  Receive-side monitor for the multiplexed 8-digit 7-segment display bus (CA/AN).

---
 rtl/seg7_scan_if.sv | 24 ++
 rtl/seg7_scan_decoder.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// Scanned 7-segment display bus (CA/AN) plus the
// decoded frame results seen by a receive-side monitor.
interface seg7_scan_if #(
  parameter int NDIG  = 8,
  parameter int VAL_W = 27
);
  logic [7:0]       CA;
  logic [NDIG-1:0]  AN;
  logic [VAL_W-1:0] value;
  logic             valid;
  logic [NDIG-1:0]  dp;
  logic             err_seg;
  logic             err_seq;

  modport master (
    output CA, AN,
    input  value, valid, dp, err_seg, err_seq
  );

  modport slave (
    input  CA, AN,
    output value, valid, dp, err_seg, err_seq
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 8-digit 7-segment bus,
// rebuilds one frame and converts it to binary.
module seg7_scan_decoder #(
  parameter int NDIG  = 8,
  parameter int VAL_W = 27
) (
  input logic       clk,
  input logic       rst,
  seg7_scan_if.slave bus
);

  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CONVERT
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [IDX_W-1:0]           k_q, k_d;
  logic [NDIG-1:0][3:0]       dig_q, dig_d;
  logic [NDIG-1:0]            dpb_q, dpb_d;
  logic [VAL_W-1:0]           acc_q, acc_d;
  logic [VAL_W-1:0]           value_q, value_d;
  logic [NDIG-1:0]            dp_q, dp_d;
  logic                       valid_q, valid_d;
  logic                       err_seg_q, err_seg_d;
  logic                       err_seq_q, err_seq_d;

  logic                       seg_ok;
  logic [3:0]                 seg_val;
  logic [IDX_W-1:0]           nxt_idx;
  logic [IDX_W-1:0]           cap_idx;
  logic                       an_cur;
  logic                       an_nxt;
  logic                       an_idle;
  logic [VAL_W-1:0]           acc_nx;

  function automatic logic [NDIG-1:0] sel_of(
    input logic [IDX_W-1:0] i
  );
    logic [NDIG-1:0] one;
    one = {{(NDIG-1){1'b0}}, 1'b1};
    return ~(one << i);
  endfunction

  // Active-low segment pattern to digit; blank reads as 0
  always_comb begin
    seg_ok  = 1'b1;
    seg_val = 4'd0;
    unique case (bus.CA[6:0])
      7'h40:   seg_val = 4'd0;
      7'h79:   seg_val = 4'd1;
      7'h24:   seg_val = 4'd2;
      7'h30:   seg_val = 4'd3;
      7'h19:   seg_val = 4'd4;
      7'h12:   seg_val = 4'd5;
      7'h02:   seg_val = 4'd6;
      7'h78:   seg_val = 4'd7;
      7'h00:   seg_val = 4'd8;
      7'h18:   seg_val = 4'd9;
      7'h7F:   seg_val = 4'd0;
      default: seg_ok  = 1'b0;
    endcase
  end

  // Anode pattern classification relative to the last captured digit
  always_comb begin
    nxt_idx = idx_q + 1'b1;
    an_cur  = (bus.AN == sel_of(idx_q));
    an_nxt  = (idx_q != LAST) && (bus.AN == sel_of(nxt_idx));
    an_idle = &bus.AN;
    acc_nx  = (acc_q << 3) + (acc_q << 1)
            + VAL_W'(dig_q[k_q]);
  end

  // Frame capture / conversion state machine next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    k_d       = k_q;
    dig_d     = dig_q;
    dpb_d     = dpb_q;
    acc_d     = acc_q;
    value_d   = value_q;
    dp_d      = dp_q;
    valid_d   = 1'b0;
    err_seg_d = 1'b0;
    err_seq_d = 1'b0;
    cap_idx   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.AN == sel_of('0)) begin
          if (!seg_ok) begin
            err_seg_d = 1'b1;
          end else begin
            dig_d[0] = seg_val;
            dpb_d[0] = ~bus.CA[7];
            idx_d    = '0;
            state_d  = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (an_cur || an_nxt) begin
          if (!seg_ok) begin
            err_seg_d = 1'b1;
            state_d   = IDLE;
          end else begin
            cap_idx        = an_nxt ? nxt_idx : idx_q;
            dig_d[cap_idx] = seg_val;
            dpb_d[cap_idx] = ~bus.CA[7];
            idx_d          = cap_idx;
          end
        end else if (idx_q == LAST) begin
          acc_d   = '0;
          k_d     = LAST;
          state_d = CONVERT;
        end else if (!an_idle) begin
          err_seq_d = 1'b1;
          state_d   = IDLE;
        end
      end
      CONVERT: begin
        acc_d = acc_nx;
        k_d   = k_q - 1'b1;
        if (k_q == '0) begin
          value_d = acc_nx;
          dp_d    = dpb_q;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      k_q       <= '0;
      dig_q     <= '0;
      dpb_q     <= '0;
      acc_q     <= '0;
      value_q   <= '0;
      dp_q      <= '0;
      valid_q   <= 1'b0;
      err_seg_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      k_q       <= k_d;
      dig_q     <= dig_d;
      dpb_q     <= dpb_d;
      acc_q     <= acc_d;
      value_q   <= value_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      err_seg_q <= err_seg_d;
      err_seq_q <= err_seq_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.dp      = dp_q;
  assign bus.valid   = valid_q;
  assign bus.err_seg = err_seg_q;
  assign bus.err_seq = err_seq_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed-vector bench for seg7_scan_decoder.
// Drives on negedge, samples on the following negedge.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;

  seg7_scan_if #(.NDIG(8), .VAL_W(27)) bus ();

  seg7_scan_decoder #(.NDIG(8), .VAL_W(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.valid) valid_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sel(input int i);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << i);
  endfunction

  function automatic logic [7:0] seg(input int d, input bit lit);
    logic [7:0] c;
    case (d)
      0: c = 8'h40;
      1: c = 8'h79;
      2: c = 8'h24;
      3: c = 8'h30;
      4: c = 8'h19;
      5: c = 8'h12;
      6: c = 8'h02;
      7: c = 8'h78;
      8: c = 8'h00;
      default: c = 8'h18;
    endcase
    c[7] = ~lit;
    return c;
  endfunction

  task automatic drive(input logic [7:0] an, input logic [7:0] ca);
    @(negedge clk);
    bus.AN = an;
    bus.CA = ca;
  endtask

  // frame-end vector, then expect valid exactly 8 edges later
  task automatic finish_frame(input string tag,
                              input logic [7:0] an,
                              input logic [7:0] ca,
                              input logic [26:0] val,
                              input logic [7:0] dpx);
    int early;
    early = 0;
    drive(an, ca);
    drive(8'hFF, 8'hFF);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 8 && bus.valid) early++;
    end
    chk({tag, "_early"}, early, 0);
    chk({tag, "_valid"}, bus.valid, 1'b1);
    chk({tag, "_value"}, bus.value, val);
    chk({tag, "_dp"}, bus.dp, dpx);
    @(negedge clk);
    chk({tag, "_pulse"}, bus.valid, 1'b0);
    chk({tag, "_hold"}, bus.value, val);
  endtask

  initial begin
    int d [8];
    int vc;
    bus.AN = 8'hFF;
    bus.CA = 8'hFF;
    #12;
    chk("rst_value", bus.value, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_dp", bus.dp, 0);
    chk("rst_errs", {bus.err_seg, bus.err_seq}, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(8'hFF, 8'hFF);

    // 1: 00012345, one cycle per digit, end on all-ones
    d = '{5, 4, 3, 2, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) drive(sel(i), seg(d[i], 0));
    drive(sel(7), seg(d[7], 0));
    finish_frame("t1", 8'hFF, 8'hFF, 27'd12345, 8'h00);

    // 2: all nines, end on digit 0 (not captured)
    for (int i = 0; i < 8; i++) drive(sel(i), seg(9, 0));
    finish_frame("t2", 8'hFE, seg(1, 1), 27'h5F5E0FF, 8'h00);
    repeat (2) drive(8'hFF, 8'hFF);

    // 3: skipped digit -> err_seq, then a clean frame of sevens
    vc = valid_cnt;
    drive(sel(0), seg(7, 0));
    drive(sel(1), seg(7, 0));
    drive(sel(3), seg(7, 0));
    drive(8'hFF, 8'hFF);
    chk("t3_err_seq", bus.err_seq, 1'b1);
    chk("t3_no_seg", bus.err_seg, 1'b0);
    drive(8'hFF, 8'hFF);
    chk("t3_seq_pulse", bus.err_seq, 1'b0);
    repeat (10) drive(8'hFF, 8'hFF);
    chk("t3_no_valid", valid_cnt - vc, 0);
    for (int i = 0; i < 8; i++) drive(sel(i), seg(7, 0));
    finish_frame("t3", 8'hFF, 8'hFF, 27'd77777777, 8'h00);

    // 4: illegal segment pattern on digit 3
    vc = valid_cnt;
    for (int i = 0; i < 3; i++) drive(sel(i), seg(i + 1, 0));
    drive(sel(3), 8'h7D);
    drive(8'hFF, 8'hFF);
    chk("t4_err_seg", bus.err_seg, 1'b1);
    chk("t4_no_seq", bus.err_seq, 1'b0);
    drive(sel(4), seg(5, 0));
    chk("t4_seg_pulse", bus.err_seg, 1'b0);
    // in IDLE these are ignored silently
    for (int i = 5; i < 8; i++) drive(sel(i), seg(5, 0));
    repeat (12) drive(8'hFF, 8'hFF);
    chk("t4_no_valid", valid_cnt - vc, 0);
    chk("t4_no_seq2", bus.err_seq, 1'b0);
    chk("t4_value_kept", bus.value, 27'd77777777);

    // 5: held digits with gaps, dp lit on digit 2
    for (int i = 0; i < 8; i++) begin
      repeat (3) drive(sel(i), seg(i + 1, i == 2));
      if (i < 7) drive(8'hFF, 8'hFF);
    end
    finish_frame("t5", 8'hFF, 8'hFF, 27'd87654321, 8'b00000100);

    // 6: async reset three edges into CONVERT
    vc = valid_cnt;
    for (int i = 0; i < 8; i++) drive(sel(i), seg(3, 1));
    drive(8'hFF, 8'hFF);
    drive(8'hFF, 8'hFF);
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_value", bus.value, 0);
    chk("t6_dp", bus.dp, 0);
    chk("t6_valid", bus.valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) drive(8'hFF, 8'hFF);
    chk("t6_no_valid", valid_cnt - vc, 0);
    chk("t6_value_after", bus.value, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
